// File: rtl/data_gen_pkg.sv
// Shared encodings for the up/down display-data source: step modes, control FSM states
// and bounce direction constants.
package data_gen_pkg;

   typedef enum logic [1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_FREEZE = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/data_gen_updown_tick_prescaler.sv
// Step prescaler: counts 0..TICK_MAX while en is high and frees the count otherwise,
// producing a registered strobe that is high while the count sits at TICK_MAX.
module tick_prescaler #(
   parameter int TICK_MAX = 4_999_999
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MAX);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic             tick_q;

   // tick_q tracks (cnt_q == CNT_LAST) and is held with the count, so a strobe
   // pending when the count is frozen is delivered on resume instead of lost.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else if (clr) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else if (en) begin
         cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
         tick_q <= (cnt_q == CNT_PRE);
      end
   end

   assign tick = tick_q & en;

endmodule

// File: rtl/data_gen_updown.sv
// Display-data source with run/hold/clear control and up/down/bounce/freeze stepping.
// Build option DATA_GEN_SIGNED_EN extends the range down to -DATA_MAX and drives sign.
module data_gen_updown
   import data_gen_pkg::*;
#(
   parameter int              TICK_MAX = 23'd4_999_999,
   parameter int              DIGITS   = 6,
   parameter int              DATA_W   = 20,
   parameter logic [DATA_W-1:0] DATA_MAX = 20'd999_999,
   parameter logic [DIGITS-1:0] DP_MASK  = '0
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              start,
   input  logic              stop,
   input  logic              clr,
   input  logic [1:0]        mode,
   input  logic              blank,
   output logic [DATA_W-1:0] data,
   output logic              sign,
   output logic [DIGITS-1:0] dp,
   output logic              seg_en,
   output logic              tick,
   output logic              wrap
);

`ifdef DATA_GEN_SIGNED_EN
   // Two's-complement value, one bit wider than the magnitude.
   localparam int VAL_W = DATA_W + 1;
`else
   localparam int VAL_W = DATA_W;
`endif

   localparam logic [VAL_W-1:0] ONE_V = VAL_W'(1);
   localparam logic [VAL_W-1:0] HI_V  = VAL_W'(DATA_MAX);
`ifdef DATA_GEN_SIGNED_EN
   localparam logic [VAL_W-1:0] LO_V  = ~HI_V + ONE_V;
`else
   localparam logic [VAL_W-1:0] LO_V  = '0;
`endif

   state_t            state_q, state_d;
   logic [VAL_W-1:0]  value_q, value_d;
   logic              dir_q, dir_d;
   logic              wrap_d;
   logic              wrap_q;
   logic [DATA_W-1:0] data_q;
   logic              seg_en_q;
   logic              run;
   logic              step;

   function automatic logic [DATA_W-1:0] mag(input logic [VAL_W-1:0] v);
`ifdef DATA_GEN_SIGNED_EN
      logic [VAL_W-1:0] neg;
      neg = ~v + ONE_V;
      return v[VAL_W-1] ? neg[DATA_W-1:0] : v[DATA_W-1:0];
`else
      return v;
`endif
   endfunction

   assign run = (state_q == ST_RUN);

   tick_prescaler #(
      .TICK_MAX (TICK_MAX)
   ) u_prescaler (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .en      (run),
      .clr     (clr),
      .tick    (tick)
   );

   assign step = tick & run;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Control priority: clr > stop > start.
   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = ST_IDLE;
      end else if (stop) begin
         if (state_q == ST_RUN) state_d = ST_HOLD;
      end else if (start) begin
         if (state_q == ST_IDLE || state_q == ST_HOLD) state_d = ST_RUN;
      end
   end

   always_comb begin
      value_d = value_q;
      dir_d   = dir_q;
      wrap_d  = 1'b0;
      case (mode_t'(mode))
         MODE_UP: begin
            if (value_q == HI_V) begin
               value_d = LO_V;
               wrap_d  = 1'b1;
            end else begin
               value_d = value_q + ONE_V;
            end
         end
         MODE_DOWN: begin
            if (value_q == LO_V) begin
               value_d = HI_V;
               wrap_d  = 1'b1;
            end else begin
               value_d = value_q - ONE_V;
            end
         end
         MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
               if (value_q == HI_V) begin
                  dir_d   = DIR_DOWN;
                  value_d = HI_V - ONE_V;
                  wrap_d  = 1'b1;
               end else begin
                  value_d = value_q + ONE_V;
               end
            end else begin
               if (value_q == LO_V) begin
                  dir_d   = DIR_UP;
                  value_d = LO_V + ONE_V;
                  wrap_d  = 1'b1;
               end else begin
                  value_d = value_q - ONE_V;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         value_q <= '0;
         dir_q   <= DIR_UP;
         wrap_q  <= 1'b0;
         data_q  <= '0;
      end else if (clr) begin
         value_q <= '0;
         dir_q   <= DIR_UP;
         wrap_q  <= 1'b0;
         data_q  <= '0;
      end else if (step) begin
         value_q <= value_d;
         dir_q   <= dir_d;
         wrap_q  <= wrap_d;
         data_q  <= mag(value_d);
      end else begin
         wrap_q  <= 1'b0;
      end
   end

`ifdef DATA_GEN_SIGNED_EN
   logic sign_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)   sign_q <= 1'b0;
      else if (clr)  sign_q <= 1'b0;
      else if (step) sign_q <= value_d[VAL_W-1];
   end

   assign sign = sign_q;
`else
   assign sign = 1'b0;
`endif

   // Display enable follows blank regardless of run state, but stays low through reset.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) seg_en_q <= 1'b0;
      else         seg_en_q <= ~blank;
   end

   assign data   = data_q;
   assign wrap   = wrap_q;
   assign seg_en = seg_en_q;
   assign dp     = DP_MASK;

endmodule

// File: tb/tb_data_gen_updown.sv
// Bench for data_gen_updown: directed scenarios then random control, checked every
// cycle against an integer model of the run/hold/step rules.
module tb_data_gen_updown;

   localparam int TM   = 3;
   localparam int DMAX = 5;
   localparam logic [5:0] DPM = 6'b100_101;

   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_HOLD = 2;

   logic        sys_clk;
   logic        sys_rst;
   logic        start, stop, clr, blank;
   logic [1:0]  mode;
   logic [19:0] data;
   logic        sign, seg_en, tick, wrap;
   logic [5:0]  dp;

   int checks   = 0;
   int failures = 0;

   // model state
   int m_st, m_cnt, m_val, m_dir, m_wrap, m_seg;
`ifdef DATA_GEN_SIGNED_EN
   int m_lo = -DMAX;
`else
   int m_lo = 0;
`endif

   data_gen_updown #(
      .TICK_MAX (TM),
      .DIGITS   (6),
      .DATA_W   (20),
      .DATA_MAX (20'd5),
      .DP_MASK  (DPM)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .start   (start),
      .stop    (stop),
      .clr     (clr),
      .mode    (mode),
      .blank   (blank),
      .data    (data),
      .sign    (sign),
      .dp      (dp),
      .seg_en  (seg_en),
      .tick    (tick),
      .wrap    (wrap)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === 32'(exp)) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = S_IDLE; m_cnt = 0; m_val = 0; m_dir = 0; m_wrap = 0; m_seg = 0;
   endtask

   task automatic model_edge();
      int nv, nd, nw;
      if (sys_rst) begin
         model_reset();
         return;
      end
      nv = m_val; nd = m_dir; nw = 0;
      if (m_st == S_RUN && m_cnt == TM) begin
         case (mode)
            2'd0: if (m_val == DMAX) begin nv = m_lo; nw = 1; end else nv = m_val + 1;
            2'd1: if (m_val == m_lo) begin nv = DMAX; nw = 1; end else nv = m_val - 1;
            2'd2: begin
               if (m_dir == 0) begin
                  if (m_val == DMAX) begin nd = 1; nv = DMAX - 1; nw = 1; end
                  else nv = m_val + 1;
               end else begin
                  if (m_val == m_lo) begin nd = 0; nv = m_lo + 1; nw = 1; end
                  else nv = m_val - 1;
               end
            end
            default: ;
         endcase
      end
      if (m_st == S_RUN) m_cnt = (m_cnt == TM) ? 0 : m_cnt + 1;
      if (clr) m_st = S_IDLE;
      else if (stop) begin if (m_st == S_RUN) m_st = S_HOLD; end
      else if (start) begin if (m_st != S_RUN) m_st = S_RUN; end
      m_val = nv; m_dir = nd; m_wrap = nw;
      if (clr) begin m_cnt = 0; m_val = 0; m_dir = 0; m_wrap = 0; end
      m_seg = blank ? 0 : 1;
   endtask

   function automatic int m_tick();
      return (m_st == S_RUN && m_cnt == TM) ? 1 : 0;
   endfunction

   task automatic compare_all(input string ph);
      chk({ph, ".tick"},   32'(tick),   m_tick());
      chk({ph, ".data"},   32'(data),   (m_val < 0) ? -m_val : m_val);
      chk({ph, ".sign"},   32'(sign),   (m_val < 0) ? 1 : 0);
      chk({ph, ".wrap"},   32'(wrap),   m_wrap);
      chk({ph, ".seg_en"}, 32'(seg_en), m_seg);
      chk({ph, ".dp"},     32'(dp),     int'(DPM));
   endtask

   task automatic cyc(input string ph);
      @(posedge sys_clk);
      model_edge();
      #1;
      compare_all(ph);
   endtask

   task automatic run_cycles(input string ph, input int n);
      for (int i = 0; i < n; i++) cyc(ph);
   endtask

   task automatic pulse_start(input string ph);
      start = 1'b1;
      cyc(ph);
      start = 1'b0;
   endtask

   task automatic run_until_val(input string ph, input int v);
      for (int i = 0; i < 200 && m_val != v; i++) cyc(ph);
      chk({ph, ".reach"}, 32'(data), (v < 0) ? -v : v);
   endtask

   initial begin
      sys_rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; blank = 1'b0; mode = 2'd0;
      model_reset();
      #12;
      compare_all("reset");
      sys_rst = 1'b0;

      // up: 0..5 then wrap to low bound
      cyc("seg_on");
      mode = 2'd0;
      pulse_start("up");
      run_cycles("up", 4 * 8);

      // down from 0
      clr = 1'b1; cyc("clr1"); clr = 1'b0;
      mode = 2'd1;
      pulse_start("down");
      run_cycles("down", 4 * 14);

      // bounce
      clr = 1'b1; cyc("clr2"); clr = 1'b0;
      mode = 2'd2;
      pulse_start("bounce");
      run_cycles("bounce", 4 * 26);

      // hold at 3 then resume
      clr = 1'b1; cyc("clr3"); clr = 1'b0;
      mode = 2'd0;
      pulse_start("hold");
      run_until_val("hold", 3);
      stop = 1'b1; cyc("hold"); stop = 1'b0;
      run_cycles("hold", 20);
      pulse_start("resume");
      run_cycles("resume", 12);

      // stop landing on the strobe cycle must not lose the step
      for (int i = 0; i < 10 && m_tick() == 0; i++) cyc("tstop");
      stop = 1'b1; cyc("tstop"); stop = 1'b0;
      run_cycles("tstop", 5);
      pulse_start("tres");
      run_cycles("tres", 10);

      // clr with start and stop at data 4
      run_until_val("clrall", 4);
      clr = 1'b1; start = 1'b1; stop = 1'b1;
      cyc("clrall");
      clr = 1'b0; start = 1'b0; stop = 1'b0;
      run_cycles("idle", 6);

      // freeze while running
      pulse_start("frz");
      run_cycles("frz", 6);
      mode = 2'd3;
      run_cycles("frz", 14);

      // async reset while tick is high
      mode = 2'd0;
      for (int i = 0; i < 10 && m_tick() == 0; i++) cyc("arst");
      chk("arst.pre_tick", 32'(tick), 1);
      #1 sys_rst = 1'b1;
      #1 model_reset();
      compare_all("arst");
      cyc("arst_hold");
      sys_rst = 1'b0;
      cyc("arst_rel");
      blank = 1'b1; cyc("blank");
      blank = 1'b0; cyc("unblank");

      // random control
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         start = ($urandom_range(0, 5) == 0);
         stop  = ($urandom_range(0, 19) == 0);
         clr   = ($urandom_range(0, 99) == 0);
         blank = ($urandom_range(0, 9) == 0);
         cyc("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_gen_updown.md
Name: data_gen_updown

Overview:
Parametrised display-data source for the seven-segment/595 display path; next generation of the fixed 0..999999 up-counter source. Adds programmable step period, digit count, decimal-point mask, up/down/bounce modes, run/hold/clear control and optional signed range. Drives data, dp, sign and seg_en into the BCD/segment driver.

Parameters:
TICK_MAX, 23'd4_999_999, prescaler terminal count; one step every TICK_MAX+1 clocks; must be >= 1.
DIGITS, 6, number of display digits; sets dp width.
DATA_W, 20, magnitude width of data.
DATA_MAX, 20'd999_999, upper magnitude bound; must be < 2**DATA_W.
DP_MASK, 6'b000_000, constant decimal-point pattern, bit i = digit i, active high.

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous, active-high reset
start  in  1  level; request RUN
stop  in  1  level; request HOLD
clr  in  1  synchronous clear
mode  in  2  00 up, 01 down, 10 bounce, 11 freeze
blank  in  1  display blank request
data  out  DATA_W  magnitude of current value
sign  out  1  1 = value negative
dp  out  DIGITS  decimal points, = DP_MASK
seg_en  out  1  display enable
tick  out  1  one-cycle step strobe
wrap  out  1  one-cycle pulse on wrap or bounce reversal

Behaviour:
- One clock, sys_clk; sys_rst asynchronous, active-high. On reset: state IDLE, prescaler 0, value 0, dir up, data 0, sign 0, tick 0, wrap 0, seg_en 0.
- FSM: IDLE, RUN, HOLD. Control priority per cycle: clr > stop > start.
- IDLE->RUN on start. RUN->HOLD on stop. HOLD->RUN on start. Any state->IDLE on clr.
- clr: value 0, prescaler 0, dir up, tick/wrap 0; takes effect at the sampling edge.
- Prescaler counts 0..TICK_MAX and wraps, only while state==RUN; it holds its count in HOLD and IDLE.
- tick is registered: set on the edge where prescaler==TICK_MAX-1, so it is high while prescaler==TICK_MAX.
- Value updates on the edge where tick==1 and state==RUN.
- Latency: start sampled at edge E -> tick high after E+TICK_MAX -> first value change at E+TICK_MAX+1.
- Value range: internal signed DATA_W+1 bits. Bounds are LO..HI, where HI = DATA_MAX and LO = 0 (unsigned) or -DATA_MAX (signed build).
- up: value+1. At HI, value goes to LO and wrap pulses.
- down: value-1. At LO, value goes to HI and wrap pulses.
- bounce: steps in the direction held in dir. At HI with dir up, dir goes down and value goes to HI-1; at LO with dir down, dir goes up and value goes to LO+1. No dwell; wrap pulses on the reversal.
- freeze: value unchanged; prescaler and tick still run.
- Mode changes are applied on the next tick. dir is kept across mode changes.
- wrap is registered and coincides with the value update.
- data = |value| and sign = value<0, both registered and updated in the same cycle as value.
- dp = DP_MASK, combinational constant.
- seg_en is registered: 0 in reset, then ~blank from the first clock after reset release, independent of FSM state.
- Reset mid-run: all state returns to reset values immediately, asynchronously.

Optional Feature:
DATA_GEN_SIGNED_EN.
- Defined: LO = -DATA_MAX and sign reflects the value.
- Undefined: LO = 0, sign tied 0, and the internal value is DATA_W bits unsigned.

Decomposition:
- Package data_gen_pkg holds: mode encodings (MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_FREEZE), FSM state encodings, and the dir constants.
- Natural sub-module: tick_prescaler, parameter TICK_MAX, inputs en and clr, output tick.

Test Plan:
1. TICK_MAX=3, DATA_MAX=5, up. Reset, then assert start -> tick every 4 clocks; data runs 0,1,2,3,4,5,0 with wrap high on the 5->0 step; seg_en=1 one clock after reset release.
2. Down from 0 (unsigned) -> data 5, wrap=1. Signed build -> data runs 0, then 1 with sign=1, ..., down to 5 with sign=1, then 5 with sign=0 and wrap=1.
3. Bounce, unsigned, DATA_MAX=5 -> data 0..5, 4, 3, 2, 1, 0, 1; wrap pulses at 5->4 and 0->1 only.
4. stop at data=3 for 20 clocks, then start -> data stays 3 and tick stays 0 during HOLD; the next step happens after the remaining prescaler count, with no lost or extra step.
5. clr together with start and stop while data=4 -> state IDLE, data 0, sign 0, prescaler 0; freeze mode while running -> tick continues, data constant.
6. Assert sys_rst mid-step with tick=1 -> all outputs go to 0 without waiting for a clock edge. blank=1 -> seg_en=0 one clock later.
